// File: rtl/window_mean_pkg.sv
// Shared types and helpers for the sliding-window averager.
// Accumulator width and the sign/zero extension used on samples.
package window_mean_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int acc_w(
    input int width,
    input int log2_depth
  );
    return width + log2_depth;
  endfunction

  // Extends the low w bits of v to MAX_W bits; sgn picks sign vs zero.
  function automatic logic [MAX_W-1:0] ext(
    input logic [MAX_W-1:0] v,
    input int               w,
    input logic             sgn
  );
    logic [MAX_W-1:0] r;
    r = v;
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= w) r[i] = sgn & v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/window_mean_if.sv
// Sample stream in, window mean stream out.
// The master drives samples; the slave returns mean, strobe and full.
interface window_mean_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] din;
  logic             ivalid;
  logic [WIDTH-1:0] dout;
  logic             ovalid;
  logic             full;

  modport master (
    output din,
    output ivalid,
    input  dout,
    input  ovalid,
    input  full
  );

  modport slave (
    input  din,
    input  ivalid,
    output dout,
    output ovalid,
    output full
  );
endinterface

// File: rtl/window_buf.sv
// Circular sample buffer, DEPTH x WIDTH.
// Combinational read of the oldest entry, registered write.
module window_buf #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] oldest
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;

  // The slot about to be overwritten holds the oldest sample.
  assign oldest = mem[wr_ptr];

  // Write pointer; wraps for free at the power-of-two depth.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
    end else if (we) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Sample storage is deliberately left uninitialised on reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/window_mean.sv
// Sliding-window mean over the last 2^LOG2_DEPTH accepted samples.
// Running sum plus a shift; one result per sample once full.
module window_mean
  import window_mean_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sign,
  input  logic         clear,
  window_mean_if.slave io
);

  localparam int ACC   = acc_w(WIDTH, LOG2_DEPTH);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CW    = LOG2_DEPTH + 1;

  state_t           state;
  logic [ACC-1:0]   acc;
  logic [ACC-1:0]   acc_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] oldest;
  logic [WIDTH-1:0] old;
  logic [WIDTH-1:0] mean;
  logic [WIDTH-1:0] dout;
  logic             ovalid;
  logic             full;
  logic             accept;
  logic             last;
  logic             emit;

  assign accept = io.ivalid & ~clear & ~reset;
  assign old    = (state == RUN) ? oldest : '0;
  assign last   = (state == FILL) &&
                  (count == CW'(DEPTH - 1));
  assign emit   = (state == RUN) || last;

  assign acc_next = acc
    + ACC'(ext(MAX_W'(io.din), WIDTH, sign))
    - ACC'(ext(MAX_W'(old), WIDTH, sign));

  // Divide by the window length; floor toward -inf when signed.
  always_comb begin
    mean = '0;
    if (sign) begin
      mean = WIDTH'($signed(acc_next) >>> LOG2_DEPTH);
    end else begin
      mean = WIDTH'(acc_next >> LOG2_DEPTH);
    end
  end

  window_buf #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_buf (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .we     (accept),
    .wdata  (io.din),
    .oldest (oldest)
  );

  // FILL/RUN control, running sum and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= FILL;
      acc    <= '0;
      count  <= '0;
      ovalid <= 1'b0;
      full   <= 1'b0;
      dout   <= '0;
    end else if (clear) begin
      state  <= FILL;
      acc    <= '0;
      count  <= '0;
      ovalid <= 1'b0;
      full   <= 1'b0;
    end else if (accept) begin
      acc    <= acc_next;
      ovalid <= emit;
      if (state == FILL) begin
        count <= count + 1'b1;
      end
      if (last) begin
        state <= RUN;
        full  <= 1'b1;
      end
      if (emit) begin
        dout <= mean;
      end
    end else begin
      ovalid <= 1'b0;
    end
  end

  assign io.dout   = dout;
  assign io.ovalid = ovalid;
  assign io.full   = full;

endmodule

// File: tb/tb_window_mean.sv
// Directed plus random stimulus for window_mean.
// Reference keeps the window as a queue and takes a floored mean.
module tb_window_mean;

  localparam int W  = 16;
  localparam int L2 = 2;
  localparam int D  = 1 << L2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sign  = 1'b0;
  logic clear = 1'b0;

  int checks   = 0;
  int failures = 0;

  longint   q[$];
  logic     exp_ov   = 1'b0;
  logic     exp_full = 1'b0;
  logic [W-1:0] exp_dout = '0;

  window_mean_if #(.WIDTH(W)) io ();

  window_mean #(
    .WIDTH      (W),
    .LOG2_DEPTH (L2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sign  (sign),
    .clear (clear),
    .io    (io.slave)
  );

  always #5 clock = ~clock;

  task automatic check(
    input string        tag,
    input logic [W-1:0] got,
    input logic [W-1:0] exp
  );
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mean();
    longint s;
    longint m;
    s = 0;
    foreach (q[i]) s += q[i];
    if (s < 0) m = -((-s + D - 1) / D);
    else       m = s / D;
    return W'(m);
  endfunction

  task automatic step(
    input logic         v,
    input logic [W-1:0] d,
    input logic         clr,
    input logic         rst
  );
    @(negedge clock);
    io.ivalid = v;
    io.din    = d;
    clear     = clr;
    reset     = rst;
    @(posedge clock);
    if (rst) begin
      q.delete();
      exp_ov   = 1'b0;
      exp_dout = '0;
    end else if (clr) begin
      q.delete();
      exp_ov = 1'b0;
    end else if (v) begin
      if (sign) q.push_back(longint'($signed(d)));
      else      q.push_back(longint'({48'd0, d}));
      if (q.size() > D) void'(q.pop_front());
      exp_ov = (q.size() == D);
      if (exp_ov) exp_dout = ref_mean();
    end else begin
      exp_ov = 1'b0;
    end
    exp_full = (q.size() == D);
    #1;
    check("ovalid", W'(io.ovalid), W'(exp_ov));
    check("full",   W'(io.full),   W'(exp_full));
    check("dout",   io.dout,       exp_dout);
    @(negedge clock);
    io.ivalid = 1'b0;
    clear     = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic put(input logic [W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_clear(input logic s);
    sign = s;
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    io.din    = '0;
    io.ivalid = 1'b0;

    step(1'b0, '0, 1'b0, 1'b1);
    check("rst_dout", io.dout, 16'h0000);
    idle(5);
    check("idle_full", W'(io.full), 16'h0000);
    do_clear(1'b0);

    put(16'd4); put(16'd8); put(16'd12); put(16'd16);
    check("u_mean10", io.dout, 16'd10);
    check("u_full", W'(io.full), 16'd1);
    put(16'd20);
    check("u_mean14", io.dout, 16'd14);

    do_clear(1'b0);
    put(16'd4);  idle(3);
    put(16'd8);  idle(3);
    put(16'd12); idle(3);
    put(16'd16);
    check("gap_mean10", io.dout, 16'd10);
    idle(3);
    put(16'd20);
    check("gap_mean14", io.dout, 16'd14);

    do_clear(1'b1);
    put(-16'sd31); put(16'sd11); put(-16'sd5); put(16'sd1);
    check("s_mean_m6", io.dout, 16'hFFFA);
    put(16'sd3);
    check("s_mean_2", io.dout, 16'd2);
    do_clear(1'b1);
    put(16'hFFFF); put(16'hFFFF); put(16'hFFFF); put(16'h0000);
    check("s_floor", io.dout, 16'hFFFF);

    do_clear(1'b0);
    for (int i = 0; i < 9; i++) put(16'hFFFF);
    check("u_max", io.dout, 16'hFFFF);
    do_clear(1'b1);
    for (int i = 0; i < 9; i++) put(16'h8000);
    check("s_min", io.dout, 16'h8000);

    do_clear(1'b0);
    put(16'd5); put(16'd6); put(16'd7); put(16'd8);
    step(1'b1, 16'd100, 1'b1, 1'b0);
    check("clr_hold", io.dout, 16'd6);
    check("clr_full", W'(io.full), 16'd0);
    put(16'd1); put(16'd2); put(16'd3); put(16'd4);
    check("clr_mean2", io.dout, 16'd2);

    put(16'd9);
    step(1'b1, 16'd50, 1'b0, 1'b1);
    check("rst_mid", io.dout, 16'd0);
    for (int i = 0; i < 4; i++) put(16'd8);
    check("rst_mean8", io.dout, 16'd8);

    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 29);
      if (r == 0) begin
        do_clear(1'($urandom_range(0, 1)));
      end else if (r == 1) begin
        sign = 1'($urandom_range(0, 1));
        step(1'($urandom_range(0, 1)), W'($urandom),
             1'b0, 1'b1);
      end else begin
        step(1'($urandom_range(0, 3) != 0), W'($urandom),
             1'b0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
